// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the fetch-stage next-PC sequencer.
// Holds the FSM state enum, the redirect record and the default address map.
package pc_ctrl_pkg;

    localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_3000;
    localparam logic [31:0] DEF_LIMIT_ADDR = 32'h0000_307C;

    typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} seq_state_e;

    typedef enum logic [1:0] {NONE, BR, JMP} redir_kind_e;

    // One redirect request: what kind it is and where it goes.
    typedef struct packed {
        redir_kind_e kind;
        logic [31:0] target;
    } redir_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Control/address bundle between the hazard unit, decode, EX and the
// sequencer. master = environment driving redirects, slave = sequencer.
interface pc_fetch_sequencer_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_base;
    logic [31:0] br_offset;
    logic        jmp;
    logic [31:0] jmp_pc;
    logic [25:0] jmp_index;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush_if;
    logic        flush_id;
    logic        redir_pend;
    logic        halted;

    modport master (
        output stall, br_taken, br_base, br_offset, jmp, jmp_pc, jmp_index,
        input  pc, pc_valid, flush_if, flush_id, redir_pend, halted
    );

    modport slave (
        input  stall, br_taken, br_base, br_offset, jmp, jmp_pc, jmp_index,
        output pc, pc_valid, flush_if, flush_id, redir_pend, halted
    );
endinterface

// File: rtl/pc_fetch_sequencer_target_calc.sv
// Combinational redirect target generation. Produces the live redirect for
// this cycle; a resolved branch outranks a same-cycle jump (wrong path).
module pc_target_calc
    import pc_ctrl_pkg::*;
(
    input  logic        br_taken,
    input  logic [31:0] br_base,
    input  logic [31:0] br_offset,
    input  logic        jmp,
    input  logic [31:0] jmp_pc,
    input  logic [25:0] jmp_index,
    output redir_t      live
);
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic        unused_jmp_lo;

    // Branch add wraps mod 2^32; jump keeps the 256MB region of PC+4.
    assign br_tgt        = word_align(br_base + (br_offset << 2));
    assign jmp_tgt       = {jmp_pc[31:28], jmp_index, 2'b00};
    assign unused_jmp_lo = ^jmp_pc[27:0];

    // Pick this cycle's redirect, branch first.
    always_comb begin
        live = '{kind: NONE, target: '0};
        if (br_taken)
            live = '{kind: BR, target: br_tgt};
        else if (jmp)
            live = '{kind: JMP, target: jmp_tgt};
    end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Next-PC sequencer for the fetch stage: owns the PC register, arbitrates
// sequential / branch / jump, parks redirects seen under stall and raises
// IF/ID flush pulses in the cycle the new PC appears.
// Optional build macro PC_HALT_LIMIT_EN: park at LIMIT_ADDR until redirected.
module pc_fetch_sequencer
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VEC  = DEF_RESET_VEC,
    parameter logic [31:0] LIMIT_ADDR = DEF_LIMIT_ADDR
) (
    input logic                 clk,
    input logic                 rst_n,
    pc_fetch_sequencer_if.slave bus
);
    seq_state_e  state;
    redir_t      pend;
    redir_t      pend_nxt;
    redir_t      live;
    redir_t      apply;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        pc_valid_q;
    logic        flush_if_q;
    logic        flush_id_q;
    logic        halt_hit;

    pc_target_calc u_calc (
        .br_taken  (bus.br_taken),
        .br_base   (bus.br_base),
        .br_offset (bus.br_offset),
        .jmp       (bus.jmp),
        .jmp_pc    (bus.jmp_pc),
        .jmp_index (bus.jmp_index),
        .live      (live)
    );

    // A parked redirect beats anything arriving in the release cycle.
    always_comb begin
        apply   = (pend.kind != NONE) ? pend : live;
        next_pc = (apply.kind != NONE) ? apply.target : pc_q + 32'd4;
    end

    // Parking rules under stall: branch replaces a parked jump, the first
    // branch is kept, and a jump only lands in an empty slot.
    always_comb begin
        pend_nxt = pend;
        if (live.kind == BR && pend.kind != BR)
            pend_nxt = live;
        else if (live.kind == JMP && pend.kind == NONE)
            pend_nxt = live;
    end

`ifdef PC_HALT_LIMIT_EN
    logic halted_q;
    assign halt_hit   = (pc_q >= LIMIT_ADDR) && (apply.kind == NONE);
    assign bus.halted = halted_q;
`else
    logic unused_limit;
    assign halt_hit     = 1'b0;
    assign unused_limit = ^LIMIT_ADDR;
    assign bus.halted   = 1'b0;
`endif

    assign bus.pc         = pc_q;
    assign bus.pc_valid   = pc_valid_q;
    assign bus.flush_if   = flush_if_q;
    assign bus.flush_id   = flush_id_q;
    assign bus.redir_pend = (pend.kind != NONE);

    // Sequencer FSM: PC register, pending slot and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            flush_if_q <= 1'b0;
            flush_id_q <= 1'b0;
            pend       <= '{kind: NONE, target: '0};
`ifdef PC_HALT_LIMIT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            flush_if_q <= 1'b0;
            flush_id_q <= 1'b0;
            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN, STALL: begin
                    if (bus.stall) begin
                        pend  <= pend_nxt;
                        state <= STALL;
                    end else if (halt_hit) begin
`ifdef PC_HALT_LIMIT_EN
                        halted_q <= 1'b1;
`endif
                        pc_valid_q <= 1'b0;
                        state      <= HALT;
                    end else begin
                        pc_q       <= word_align(next_pc);
                        flush_if_q <= (apply.kind != NONE);
                        flush_id_q <= (apply.kind == BR);
                        pend       <= '{kind: NONE, target: '0};
                        state      <= RUN;
                    end
                end
`ifdef PC_HALT_LIMIT_EN
                HALT: begin
                    if (live.kind != NONE) begin
                        pc_q       <= word_align(live.target);
                        flush_if_q <= 1'b1;
                        flush_id_q <= (live.kind == BR);
                        pc_valid_q <= 1'b1;
                        halted_q   <= 1'b0;
                        state      <= RUN;
                    end
                end
`endif
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: each row drives one cycle of
// inputs and pushes the outputs expected after that edge.
module tb_pc_fetch_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic        fi;
        logic        fd;
        logic        rp;
        logic        h;
    } obs_t;

    typedef struct packed {
        logic        st;
        logic        br;
        logic [31:0] bb;
        logic [31:0] bo;
        logic        j;
        logic [31:0] jp;
        logic [25:0] ji;
        obs_t        e;
    } row_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    obs_t sb[$];

    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t rw(input logic st, input logic br, input logic [31:0] bb,
                                input logic [31:0] bo, input logic j, input logic [25:0] ji,
                                input logic [31:0] epc, input logic ev, input logic efi,
                                input logic efd, input logic erp, input logic eh);
        row_t r;
        r.st = st; r.br = br; r.bb = bb; r.bo = bo;
        r.j  = j;  r.jp = 32'h0000_3010; r.ji = ji;
        r.e  = '{pc: epc, v: ev, fi: efi, fd: efd, rp: erp, h: eh};
        return r;
    endfunction

    function automatic obs_t sample();
        return '{pc: bus.pc, v: bus.pc_valid, fi: bus.flush_if, fd: bus.flush_id,
                 rp: bus.redir_pend, h: bus.halted};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h v=%b fi=%b fd=%b rp=%b h=%b", o.pc, o.v, o.fi, o.fd, o.rp, o.h);
    endfunction

    task automatic drive(input row_t r);
        bus.stall     = r.st;
        bus.br_taken  = r.br;
        bus.br_base   = r.bb;
        bus.br_offset = r.bo;
        bus.jmp       = r.j;
        bus.jmp_pc    = r.jp;
        bus.jmp_index = r.ji;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        row_t rows[$];
        drive(rw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        sb.push_back('{pc: 32'h3000, v: 0, fi: 0, fd: 0, rp: 0, h: 0});
        @(posedge clk); #1;
        got = sample(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL reset_hold got %s want %s", fmt(got), fmt(exp));
        end
        rst_n = 1'b1;
        sb.push_back('{pc: 32'h3000, v: 0, fi: 0, fd: 0, rp: 0, h: 0});
        #1;
        got = sample(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL reset_boot got %s want %s", fmt(got), fmt(exp));
        end
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3000, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3008, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h300C, 1, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL boot_seq[%0d] got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_branch_jump();
        obs_t got, exp;
        row_t rows[$];
        rows.push_back(rw(0, 1, 32'h300C, 32'hFFFF_FFFE, 0, 0, 32'h3004, 1, 1, 1, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3008, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 1, 26'h0C10, 32'h3040, 1, 1, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3044, 1, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL branch_jump[%0d] got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_stall_pending();
        obs_t got, exp;
        row_t rows[$];
        // jump parked, branch replaces it, later jump ignored, release-cycle jump dropped
        rows.push_back(rw(1, 0, 0, 0, 1, 26'h0C10, 32'h3044, 1, 0, 0, 1, 0));
        rows.push_back(rw(1, 1, 32'h3020, 32'h4, 0, 0, 32'h3044, 1, 0, 0, 1, 0));
        rows.push_back(rw(1, 0, 0, 0, 1, 26'h0C04, 32'h3044, 1, 0, 0, 1, 0));
        rows.push_back(rw(0, 0, 0, 0, 1, 26'h0C04, 32'h3030, 1, 1, 1, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3034, 1, 0, 0, 0, 0));
        // first branch kept over a later one
        rows.push_back(rw(1, 1, 32'h3000, 32'h10, 0, 0, 32'h3034, 1, 0, 0, 1, 0));
        rows.push_back(rw(1, 1, 32'h3000, 32'h20, 0, 0, 32'h3034, 1, 0, 0, 1, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3040, 1, 1, 1, 0, 0));
        // parked jump alone flushes IF only
        rows.push_back(rw(1, 0, 0, 0, 1, 26'h0C04, 32'h3040, 1, 0, 0, 1, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3010, 1, 1, 0, 0, 0));
        // plain stall then release resumes sequential fetch
        rows.push_back(rw(1, 0, 0, 0, 0, 0, 32'h3010, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3014, 1, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL stall_pending[%0d] got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_br_jmp_same();
        obs_t got, exp;
        row_t rows[$];
        rows.push_back(rw(0, 1, 32'h3000, 32'h8, 1, 26'h0C18, 32'h3020, 1, 1, 1, 0, 0));
        rows.push_back(rw(0, 1, 32'h300F, 32'h0, 0, 0, 32'h300C, 1, 1, 1, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3010, 1, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL br_jmp_same[%0d] got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_wrap();
        obs_t got, exp;
        row_t rows[$];
        rows.push_back(rw(0, 1, 32'hFFFF_FFF8, 32'h4, 0, 0, 32'h0000_0008, 1, 1, 1, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h0000_000C, 1, 0, 0, 0, 0));
`ifndef PC_HALT_LIMIT_EN
        rows.push_back(rw(0, 1, 32'hFFFF_FFF0, 32'h3, 0, 0, 32'hFFFF_FFFC, 1, 1, 1, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h0000_0004, 1, 0, 0, 0, 0));
`endif
        rows.push_back(rw(0, 0, 0, 0, 1, 26'h0C00, 32'h3000, 1, 1, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL wrap[%0d] got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t got, exp;
        row_t rows[$];
        drive(rw(1, 0, 0, 0, 1, 26'h0C10, 0, 0, 0, 0, 0, 0));
        sb.push_back('{pc: 32'h3000, v: 1, fi: 0, fd: 0, rp: 1, h: 0});
        @(posedge clk); #1;
        got = sample(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL mid_stall_capture got %s want %s", fmt(got), fmt(exp));
        end
        rst_n = 1'b0;
        sb.push_back('{pc: 32'h3000, v: 0, fi: 0, fd: 0, rp: 0, h: 0});
        #2;
        got = sample(); exp = sb.pop_front(); checks++;
        if (got !== exp) begin
            failures++; $display("FAIL async_reset got %s want %s", fmt(got), fmt(exp));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3000, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL post_reset[%0d] got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

`ifdef PC_HALT_LIMIT_EN
    task automatic test_halt();
        obs_t got, exp;
        row_t rows[$];
        rows.push_back(rw(0, 0, 0, 0, 1, 26'h0C1C, 32'h3070, 1, 1, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3074, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3078, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h307C, 1, 0, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h307C, 0, 0, 0, 0, 1));
        rows.push_back(rw(1, 0, 0, 0, 0, 0, 32'h307C, 0, 0, 0, 0, 1));
        rows.push_back(rw(0, 0, 0, 0, 1, 26'h0C00, 32'h3000, 1, 1, 0, 0, 0));
        rows.push_back(rw(0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                failures++; $display("FAIL halt[%0d] got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        test_reset();
        test_branch_jump();
        test_stall_pending();
        test_br_jmp_same();
        test_wrap();
        test_reset_mid_stall();
`ifdef PC_HALT_LIMIT_EN
        test_halt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
